color_measure: RTL and testbench

COLOR_MEASURE -- requirements
Module: color_measure

---
 rtl/color_measure.sv | 192 +++++++++++++++++++
 tb/tb_color_measure.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_measure.sv
// Colour sensor sequencer: settles/counts R, G, B sensor edges per window.
// Ports: clk, rst, freq_in, cal_ready, R/G/B_time in; filter_select, red/green/blue, color_id, valid, busy out.
module color_measure #(
  parameter int SETTLE_CYCLES = 16,
  parameter int GRAY_THRESH   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freq_in,
  input  logic        cal_ready,
  input  logic [63:0] R_time,
  input  logic [63:0] G_time,
  input  logic [63:0] B_time,
  input  logic        start,
  output logic [1:0]  filter_select,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [1:0]  color_id,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, SETTLE_R, MEAS_R, SETTLE_G,
    MEAS_G, SETTLE_B, MEAS_B, DONE
  } state_t;

  localparam logic [63:0] SETTLE_LAST = 64'(SETTLE_CYCLES - 1);
  localparam logic [8:0]  GT          = 9'(GRAY_THRESH);

  state_t      r_state;
  logic [63:0] r_tmr;
  logic [7:0]  r_count;
  logic        r_zero;
  logic [7:0]  r_cr;
  logic [7:0]  r_cg;
  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic [1:0]  r_filter;
  logic [7:0]  r_red;
  logic [7:0]  r_green;
  logic [7:0]  r_blue;
  logic [1:0]  r_color;
  logic        r_valid;
  logic        r_busy;

  logic        w_edge;
  logic [7:0]  w_cnt_nxt;
  logic [7:0]  w_fin;
  logic [7:0]  w_max;
  logic [7:0]  w_min;
  logic [7:0]  w_spread;
  logic [1:0]  w_max_id;
  logic [1:0]  w_id;

  // A MEAS window is X cycles long; the timer counts down to 0.
  function automatic logic [63:0] f_win(input logic [63:0] t);
    return (t == 64'd0) ? 64'd0 : t - 64'd1;
  endfunction

  assign w_edge    = r_s2 & ~r_s3;
  assign w_cnt_nxt = (w_edge && r_count != 8'hFF) ? r_count + 8'd1 : r_count;
  // Zero-length windows still take one cycle but must report 0.
  assign w_fin     = r_zero ? 8'd0 : w_cnt_nxt;

  // Blue is still in flight on the last MEAS_B cycle, so use w_fin.
  always_comb begin
    w_max    = r_cr;
    w_max_id = 2'd1;
    if (r_cg > w_max) begin
      w_max    = r_cg;
      w_max_id = 2'd2;
    end
    if (w_fin > w_max) begin
      w_max    = w_fin;
      w_max_id = 2'd3;
    end
    w_min = r_cr;
    if (r_cg < w_min) w_min = r_cg;
    if (w_fin < w_min) w_min = w_fin;
    w_spread = w_max - w_min;
    w_id     = ({1'b0, w_spread} < GT) ? 2'd0 : w_max_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_tmr    <= '0;
      r_count  <= '0;
      r_zero   <= 1'b0;
      r_cr     <= '0;
      r_cg     <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_filter <= 2'b01;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_color  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_s1    <= freq_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;
      if (r_state != IDLE && !cal_ready) begin
        r_state  <= IDLE;
        r_filter <= 2'b01;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (start && cal_ready) begin
            r_state  <= SETTLE_R;
            r_filter <= 2'b00;
            r_busy   <= 1'b1;
            r_tmr    <= SETTLE_LAST;
          end
          SETTLE_R: if (r_tmr == 64'd0) begin
            r_state <= MEAS_R;
            r_tmr   <= f_win(R_time);
            r_zero  <= (R_time == 64'd0);
            r_count <= '0;
          end else r_tmr <= r_tmr - 64'd1;
          MEAS_R: if (r_tmr == 64'd0) begin
            r_cr     <= w_fin;
            r_state  <= SETTLE_G;
            r_filter <= 2'b11;
            r_tmr    <= SETTLE_LAST;
          end else begin
            r_tmr   <= r_tmr - 64'd1;
            r_count <= w_cnt_nxt;
          end
          SETTLE_G: if (r_tmr == 64'd0) begin
            r_state <= MEAS_G;
            r_tmr   <= f_win(G_time);
            r_zero  <= (G_time == 64'd0);
            r_count <= '0;
          end else r_tmr <= r_tmr - 64'd1;
          MEAS_G: if (r_tmr == 64'd0) begin
            r_cg     <= w_fin;
            r_state  <= SETTLE_B;
            r_filter <= 2'b10;
            r_tmr    <= SETTLE_LAST;
          end else begin
            r_tmr   <= r_tmr - 64'd1;
            r_count <= w_cnt_nxt;
          end
          SETTLE_B: if (r_tmr == 64'd0) begin
            r_state <= MEAS_B;
            r_tmr   <= f_win(B_time);
            r_zero  <= (B_time == 64'd0);
            r_count <= '0;
          end else r_tmr <= r_tmr - 64'd1;
          MEAS_B: if (r_tmr == 64'd0) begin
            r_red    <= r_cr;
            r_green  <= r_cg;
            r_blue   <= w_fin;
            r_color  <= w_id;
            r_valid  <= 1'b1;
            r_state  <= DONE;
            r_filter <= 2'b01;
          end else begin
            r_tmr   <= r_tmr - 64'd1;
            r_count <= w_cnt_nxt;
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state  <= IDLE;
            r_filter <= 2'b01;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign filter_select = r_filter;
  assign red           = r_red;
  assign green         = r_green;
  assign blue          = r_blue;
  assign color_id      = r_color;
  assign valid         = r_valid;
  assign busy          = r_busy;

endmodule

// File: tb/tb_color_measure.sv
// Directed bench for color_measure with a per-filter periodic sensor model.
// Ports: drives all DUT inputs, checks all outputs.
module tb_color_measure;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freq_in = 1'b0;
  logic        cal_ready = 1'b1;
  logic [63:0] R_time = 64'd1000;
  logic [63:0] G_time = 64'd1000;
  logic [63:0] B_time = 64'd1000;
  logic        start = 1'b0;
  logic [1:0]  filter_select;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic [1:0]  color_id;
  logic        valid;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int pr = 10;
  int pg = 10;
  int pb = 10;
  int ph = 0;

  color_measure #(.SETTLE_CYCLES(4), .GRAY_THRESH(32)) dut (
    .clk(clk), .rst(rst), .freq_in(freq_in), .cal_ready(cal_ready),
    .R_time(R_time), .G_time(G_time), .B_time(B_time), .start(start),
    .filter_select(filter_select), .red(red), .green(green),
    .blue(blue), .color_id(color_id), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    int p;
    case (filter_select)
      2'b00:   p = pr;
      2'b11:   p = pg;
      2'b10:   p = pb;
      default: p = 0;
    endcase
    if (p < 2) freq_in = 1'b0;
    else begin
      ph = (ph + 1 >= p) ? 0 : ph + 1;
      freq_in = (ph < p / 2);
    end
  end

  int nv, c00, c11, c10, to;
  logic [7:0] ored, ogrn, oblu;
  logic [1:0] ocol;

  task automatic run_meas();
    int fin;
    nv = 0; c00 = 0; c11 = 0; c10 = 0; fin = 0;
    ored = 0; ogrn = 0; oblu = 0; ocol = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (filter_select == 2'b00) c00++;
      if (filter_select == 2'b11) c11++;
      if (filter_select == 2'b10) c10++;
      if (valid) begin
        nv++;
        ored = red; ogrn = green; oblu = blue; ocol = color_id;
      end
      if (!busy) begin
        fin = 1;
        break;
      end
    end
    to = !fin;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({filter_select, valid, busy} !== {2'b01, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b/%b/%b want 01/0/0", filter_select, valid, busy);
    end
    n_cmp++;
    if ({red, green, blue, color_id} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_data got %0d/%0d/%0d/%0d want 0", red, green, blue, color_id);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_cal();
    int seen;
    seen = 0;
    cal_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy || filter_select != 2'b01) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL no_cal_busy got %0d busy cycles want 0", seen);
    end
    cal_ready = 1'b1;
  endtask

  task automatic test_gray();
    pr = 10; pg = 10; pb = 10;
    R_time = 1000; G_time = 1000; B_time = 1000;
    run_meas();
    n_cmp++;
    if (to != 0 || nv != 1) begin
      n_bad++;
      $display("FAIL gray_valid got to=%0d nv=%0d want 0/1", to, nv);
    end
    n_cmp++;
    if (c00 != 1004 || c11 != 1004 || c10 != 1004) begin
      n_bad++;
      $display("FAIL gray_dur got %0d/%0d/%0d want 1004", c00, c11, c10);
    end
    n_cmp++;
    if (ored < 99 || ored > 101 || ogrn < 99 || ogrn > 101 ||
        oblu < 99 || oblu > 101) begin
      n_bad++;
      $display("FAIL gray_rgb got %0d/%0d/%0d want 100+-1", ored, ogrn, oblu);
    end
    n_cmp++;
    if (ocol !== 2'd0) begin
      n_bad++;
      $display("FAIL gray_id got %0d want 0", ocol);
    end
  endtask

  task automatic test_red();
    pr = 5; pg = 20; pb = 25;
    run_meas();
    n_cmp++;
    if (to != 0 || nv != 1) begin
      n_bad++;
      $display("FAIL red_valid got to=%0d nv=%0d want 0/1", to, nv);
    end
    n_cmp++;
    if (ored < 199 || ored > 201 || ogrn < 49 || ogrn > 51 ||
        oblu < 39 || oblu > 41) begin
      n_bad++;
      $display("FAIL red_rgb got %0d/%0d/%0d want 200/50/40", ored, ogrn, oblu);
    end
    n_cmp++;
    if (ocol !== 2'd1) begin
      n_bad++;
      $display("FAIL red_id got %0d want 1", ocol);
    end
  endtask

  task automatic test_dominant();
    pr = 20; pg = 5; pb = 20;
    run_meas();
    n_cmp++;
    if (ocol !== 2'd2 || ogrn < 199 || ogrn > 201) begin
      n_bad++;
      $display("FAIL green_id got %0d g=%0d want 2/200", ocol, ogrn);
    end
    pr = 20; pg = 20; pb = 5;
    run_meas();
    n_cmp++;
    if (ocol !== 2'd3 || oblu < 199 || oblu > 201) begin
      n_bad++;
      $display("FAIL blue_id got %0d b=%0d want 3/200", ocol, oblu);
    end
  endtask

  task automatic test_sat_zero();
    pr = 2; pg = 10; pb = 10;
    R_time = 1000; G_time = 1000; B_time = 0;
    run_meas();
    n_cmp++;
    if (to != 0 || nv != 1) begin
      n_bad++;
      $display("FAIL sat_valid got to=%0d nv=%0d want 0/1", to, nv);
    end
    n_cmp++;
    if (ored !== 8'd255) begin
      n_bad++;
      $display("FAIL sat_red got %0d want 255", ored);
    end
    n_cmp++;
    if (oblu !== 8'd0) begin
      n_bad++;
      $display("FAIL zero_blue got %0d want 0", oblu);
    end
    n_cmp++;
    if (c10 != 5) begin
      n_bad++;
      $display("FAIL zero_dur got %0d want 5", c10);
    end
    n_cmp++;
    if (ocol !== 2'd1 || ogrn < 99 || ogrn > 101) begin
      n_bad++;
      $display("FAIL sat_id got %0d g=%0d want 1/100", ocol, ogrn);
    end
  endtask

  task automatic test_cal_drop();
    int g, fired, vs;
    g = 0; fired = 0; vs = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (filter_select == 2'b11) g++;
      if (g == 10) begin
        fired = 1;
        break;
      end
    end
    cal_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fired != 1 || busy !== 1'b0 || filter_select !== 2'b01 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL cal_drop got f=%0d b=%b fs=%b v=%b want 1/0/01/0",
               fired, busy, filter_select, valid);
    end
    cal_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (valid) vs++;
    end
    n_cmp++;
    if (vs != 0) begin
      n_bad++;
      $display("FAIL cal_novalid got %0d want 0", vs);
    end
    n_cmp++;
    if (red !== 8'd255 || blue !== 8'd0 || color_id !== 2'd1 ||
        green < 99 || green > 101) begin
      n_bad++;
      $display("FAIL cal_keep got %0d/%0d/%0d/%0d want 255/100/0/1",
               red, green, blue, color_id);
    end
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (filter_select !== 2'b00 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre got fs=%b b=%b want 00/1", filter_select, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({filter_select, red, green, blue, color_id, valid, busy} !==
        {2'b01, 24'd0, 2'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_mid got fs=%b %0d/%0d/%0d id=%0d v=%b b=%b want reset",
               filter_select, red, green, blue, color_id, valid, busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_no_cal();
    test_gray();
    test_red();
    test_dominant();
    test_sat_zero();
    test_cal_drop();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
